// File: rtl/alu_driver_if.sv
// ---------------------------------------------------------------------------
// alu_driver_if
// Purpose: groups the request, response and ALU-side signals of alu_driver
//          into one bundle.
// Modports:
//   slave  - the driver's view: it accepts requests, produces responses and
//            drives the ALU operand/opcode lines.
//   master - the environment's view: it issues requests, consumes responses
//            and returns the ALU result.
// Signals:
//   req_valid/req_ready/req_op[4:0]/req_a[31:0]/req_b[31:0] : request channel
//   rsp_valid/rsp_ready/rsp_data[31:0]/rsp_err/rsp_ovf      : response channel
//   alu_a[31:0]/alu_b[31:0]/alu_sel[4:0]/alu_s[31:0]        : ALU lines
// ---------------------------------------------------------------------------
interface alu_driver_if ();
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ovf;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_sel;
  logic [31:0] alu_s;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_s,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_ovf,
           alu_a, alu_b, alu_sel
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_s,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_ovf,
           alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_driver.sv
// ---------------------------------------------------------------------------
// alu_driver
// Purpose: initiator-side sequencer for the 32-bit combinational ALU. Takes a
//          request, presents operands with sel parked at 0, then raises sel to
//          the opcode for SETTLE_CYCLES cycles, captures the ALU result and
//          returns it over the response handshake. sel drops back to 0 after
//          every operation so a repeated opcode still re-evaluates the ALU.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   bus      - alu_driver_if.slave (request, response and ALU lines)
//   busy     - high whenever the FSM is not IDLE
//   ops_done - count of successful (non-error) responses, wraps
// Parameters:
//   SETTLE_CYCLES - cycles sel is held at the opcode before capture (1..15)
//   CNT_W         - width of ops_done
// Optional feature macro: ALU_DRV_OVF_EN
//   defined     - rsp_ovf reports add carry-out, mul upper-half nonzero and
//                 shl1 shifted-out bit
//   not defined - rsp_ovf is constant 0
//
// State table:
//   IDLE  | waiting for a request; req_ready high
//   SETUP | operands on the ALU, sel still 0
//   ISSUE | sel = opcode, settle counter running
//   RESP  | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module alu_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_driver_if.slave      bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [4:0]       alu_sel_q, alu_sel_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             op_legal;
  logic             ovf_flag;

  assign op_legal = (bus.req_op != 5'd0) && (bus.req_op <= 5'd7);

`ifdef ALU_DRV_OVF_EN
  // Flag is derived from the latched operands, which are exactly what the
  // ALU sees, so it lines up with the captured result.
  logic [63:0] prod;
  assign prod = {32'd0, alu_a_q} * {32'd0, alu_b_q};

  always_comb begin
    ovf_flag = 1'b0;
    case (op_q)
      5'd1:    ovf_flag = (alu_a_q + alu_b_q) < alu_a_q;  // carry out of bit 31
      5'd5:    ovf_flag = alu_a_q[31];
      5'd7:    ovf_flag = prod > 64'h0000_0000_FFFF_FFFF;
      default: ovf_flag = 1'b0;
    endcase
  end
`else
  assign ovf_flag = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_ovf_d   = rsp_ovf_q;
    ops_d       = ops_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (op_legal) begin
            alu_a_d = bus.req_a;
            alu_b_d = bus.req_b;
            op_d    = bus.req_op;
            state_d = S_SETUP;
          end else begin
            // Illegal opcode never touches the ALU lines.
            rsp_data_d  = 32'd0;
            rsp_err_d   = 1'b1;
            rsp_ovf_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_SETUP: begin
        alu_sel_d = op_q;
        cnt_d     = SETTLE_INIT;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d  = bus.alu_s;
          rsp_err_d   = 1'b0;
          rsp_ovf_d   = ovf_flag;
          rsp_valid_d = 1'b1;
          alu_sel_d   = 5'd0;
          state_d     = S_RESP;
        end
      end
      default: begin  // S_RESP
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (!rsp_err_q) ops_d = ops_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 5'd0;
      alu_sel_q   <= 5'd0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      rsp_data_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      ops_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_ovf_q   <= rsp_ovf_d;
      ops_q       <= ops_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign ops_done      = ops_q;

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Initiator-side sequencer for the team's 32-bit combinational ALU. The ALU takes operands `a` and `b` and a 5-bit opcode `sel`, and returns result `s`.
- Accepts operation requests over a valid/ready handshake, drives the ALU operand and opcode lines in a fixed order, waits a settle window, captures `s`, and returns the result over a second valid/ready handshake.
- The ALU re-evaluates only on a change of `sel`. The driver therefore parks `sel` at 0 between operations, so repeated identical opcodes still re-evaluate.

Parameters:
- SETTLE_CYCLES, 2, cycles `alu_sel` is held at the opcode before `alu_s` is captured; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  driver can accept a request
- req_op  in  5  opcode: 1 add, 2 and, 3 eq, 4 gt, 5 shl1, 6 shr1, 7 mul
- req_a  in  32  operand A
- req_b  in  32  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  captured ALU result
- rsp_err  out  1  request had an illegal opcode
- rsp_ovf  out  1  overflow indication (see Optional Feature)
- alu_a  out  32  to ALU `a`
- alu_b  out  32  to ALU `b`
- alu_sel  out  5  to ALU `sel`
- alu_s  in  32  from ALU `s`
- busy  out  1  state != IDLE
- ops_done  out  CNT_W  count of successful responses; wraps modulo 2^CNT_W

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: state IDLE; all registered outputs 0. That covers `alu_a`, `alu_b`, `alu_sel`, `rsp_data`, `rsp_valid`, `rsp_err`, `rsp_ovf` and `ops_done`.
- Reset mid-operation: the operation is aborted, no response is produced, and `alu_sel` returns to 0 on that edge.
- `req_ready` = (state == IDLE), decoded from the state register only; no combinational path from `req_valid`.
- `busy` = !(state == IDLE).
- States: IDLE, SETUP, ISSUE, RESP.
- IDLE:
  - On accept (`req_valid` and `req_ready`) with op in 1..7: latch `req_a`, `req_b`, `req_op`; drive `alu_a`/`alu_b` with the operands, keep `alu_sel`=0; go to SETUP.
  - On accept with op 0 or 8..31: go directly to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_ovf`=0. ALU lines are untouched.
- SETUP: one cycle, operands stable with `sel`=0. Next edge: `alu_sel`<=op, settle counter <=SETTLE_CYCLES-1, go to ISSUE.
- ISSUE: while counter != 0, decrement. When counter == 0 at an edge:
  - `rsp_data`<=`alu_s`, `rsp_err`<=0, `rsp_ovf`<=computed flag, `rsp_valid`<=1;
  - `alu_sel`<=0; go to RESP.
- RESP: hold `rsp_*` stable while `rsp_ready`=0. On `rsp_valid` and `rsp_ready`: `rsp_valid`<=0 and return to IDLE. If `rsp_err`=0, `ops_done`<=`ops_done`+1.
- Latency for a legal op:
  - `rsp_valid` is high in the cycle after edge E(1+SETTLE_CYCLES), counting the accept edge as E0; with the default, 3 edges after accept.
  - Minimum request-to-request spacing is SETTLE_CYCLES+3 cycles.
- `alu_a`/`alu_b` hold their last operands in IDLE; they are not cleared.
- Simultaneous events:
  - `req_valid` during RESP is ignored because `req_ready`=0; the request must be held.
  - A response handshake and a new request cannot complete in the same cycle.
- Arithmetic: the driver does not compute results; `rsp_data` is exactly `alu_s` sampled at capture.

Optional Feature:
- Macro: ALU_DRV_OVF_EN.
- Defined: `rsp_ovf` is computed from the latched operands and registered at capture:
  - add: bit 32 of the 33-bit sum a+b;
  - mul: upper 32 bits of the 64-bit product a*b are nonzero;
  - shl1: a[31];
  - all other ops: 0.
- Not defined: `rsp_ovf` is constant 0 and the overflow logic is absent.

Test Plan:
- Reset, then request op=1, a=5, b=7, `rsp_ready`=1:
  - `alu_sel`=0 during SETUP, then 1 for 2 cycles;
  - `rsp_data`=12 with `rsp_valid` 3 edges after accept;
  - `ops_done`=1.
- Two back-to-back op=3 requests, a=b=9 then a=9, b=8: `alu_sel` returns to 0 between them; responses are 1 then 0.
- Op=0 and op=9: one-cycle response with `rsp_err`=1, `rsp_data`=0; `alu_sel` stays 0; `ops_done` unchanged.
- Op=7, a=0x10000, b=0x10000, `rsp_ready` held 0 for 5 cycles:
  - `rsp_data`=0 stays stable and `req_ready`=0 throughout;
  - with ALU_DRV_OVF_EN, `rsp_ovf`=1.
- Op=1, a=0xFFFFFFFF, b=1: `rsp_data`=0; `rsp_ovf`=1 with the macro, 0 without.
- `rst` asserted in ISSUE: next cycle state IDLE, `alu_sel`=0, no `rsp_valid`, `ops_done` unchanged.
